// File: rtl/copy_engine_pkg.sv
// Shared types for the copy engine: CSR write command, completion-tracker
// FIFO entry and completion FSM states.
package copy_engine_pkg;

    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned LINES_W   = 9;
    localparam int unsigned INTR_ID_W = 8;

    typedef logic [INTR_ID_W-1:0] t_cmd_intr_id;

    typedef struct packed {
        logic [7:0]        num_lines;
        t_cmd_intr_id      intr_id;
        logic              use_mem_status;
        logic [ADDR_W-1:0] mem_status_addr;
    } t_wr_cmd;

    typedef enum logic [1:0] {
        CPL_IDLE        = 2'd0,
        CPL_NOTIFY_MEM  = 2'd1,
        CPL_NOTIFY_INTR = 2'd2,
        CPL_WAIT_ACK    = 2'd3
    } t_cpl_state;

    typedef struct packed {
        logic [LINES_W-1:0] lines;
        t_cmd_intr_id       intr_id;
        logic               use_mem_status;
        logic [ADDR_W-1:0]  mem_status_addr;
    } t_cpl_entry;

    // num_lines of 0 encodes a full 256-line command
    function automatic t_cpl_entry cpl_entry_from_cmd(input t_wr_cmd c);
        t_cpl_entry e;
        e.lines           = (c.num_lines == 8'd0) ? LINES_W'(256) : LINES_W'(c.num_lines);
        e.intr_id         = c.intr_id;
        e.use_mem_status  = c.use_mem_status;
        e.mem_status_addr = c.mem_status_addr;
        return e;
    endfunction

endpackage

// File: rtl/copy_engine_cpl_fifo.sv
// In-order FIFO of commands awaiting completion; head entry is exposed on first_o.
module copy_engine_cpl_fifo
    import copy_engine_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  t_cpl_entry push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output t_cpl_entry first_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    t_cpl_entry     mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic           push_ok;
    logic           pop_ok;

    // Extra pointer MSB distinguishes full from empty
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign first_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/copy_engine_completion.sv
// Tracks accepted copy commands against host line-write responses and retires them
// in order via a status write or (with COPY_ENGINE_COMPLETION_INTR_EN) an interrupt.
module copy_engine_completion
    import copy_engine_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING_CMDS = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  t_wr_cmd      cmd,
    input  logic         wr_rsp_valid,
    output logic         status_wr_valid,
    input  logic         status_wr_ready,
    output logic [63:0]  status_wr_addr,
    output logic [63:0]  status_wr_data,
    output logic         intr_valid,
    input  logic         intr_ready,
    output t_cmd_intr_id intr_id,
    input  logic         intr_ack,
    output logic [63:0]  num_cmds_done,
    output logic         rsp_overflow_err
);

    localparam int unsigned PEND_W  = 16;
    localparam int unsigned AVAIL_W = PEND_W + 1;

    t_cpl_state        state_q, state_d;
    logic [PEND_W-1:0] rsp_pending_q, rsp_pending_d;
    logic [63:0]       num_done_q, num_done_d;
    logic              ovf_q, ovf_d;
    logic              st_valid_q, st_valid_d;
    logic [63:0]       st_addr_q, st_addr_d;
    logic [63:0]       st_data_q, st_data_d;
    logic              intr_valid_q, intr_valid_d;
    t_cmd_intr_id      intr_id_q, intr_id_d;

    logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
    t_cpl_entry fifo_first;
    logic       rsp_accept, head_ready, head_use_mem;

    assign cmd_ready = reset_n & ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready;

    copy_engine_cpl_fifo #(.DEPTH(MAX_OUTSTANDING_CMDS)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (cpl_entry_from_cmd(cmd)),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .first_o     (fifo_first)
    );

    // Current-cycle response is included so the notify starts one cycle after the last line
    assign rsp_accept = wr_rsp_valid & ~(fifo_empty & (rsp_pending_q == '0));
    assign head_ready = ~fifo_empty &&
                        ((AVAIL_W'(rsp_pending_q) + AVAIL_W'(rsp_accept)) >= AVAIL_W'(fifo_first.lines));

    always_comb begin
        state_d       = state_q;
        num_done_d    = num_done_q;
        ovf_d         = ovf_q;
        st_valid_d    = st_valid_q;
        st_addr_d     = st_addr_q;
        st_data_d     = st_data_q;
        intr_valid_d  = intr_valid_q;
        intr_id_d     = intr_id_q;
        fifo_pop      = 1'b0;
        if (wr_rsp_valid && !rsp_accept) ovf_d = 1'b1;
        case (state_q)
            CPL_IDLE: begin
                if (head_ready) begin
                    if (head_use_mem) begin
                        state_d    = CPL_NOTIFY_MEM;
                        st_valid_d = 1'b1;
                        st_addr_d  = fifo_first.mem_status_addr;
                        st_data_d  = num_done_q + 64'd1;
                    end else begin
                        state_d      = CPL_NOTIFY_INTR;
                        intr_valid_d = 1'b1;
                        intr_id_d    = fifo_first.intr_id;
                    end
                end
            end
            CPL_NOTIFY_MEM: begin
                if (status_wr_ready) begin
                    st_valid_d = 1'b0;
                    fifo_pop   = 1'b1;
                    state_d    = CPL_IDLE;
                end
            end
            CPL_NOTIFY_INTR: begin
                if (intr_ready) begin
                    intr_valid_d = 1'b0;
                    state_d      = CPL_WAIT_ACK;
                end
            end
            CPL_WAIT_ACK: begin
                if (intr_ack) begin
                    fifo_pop = 1'b1;
                    state_d  = CPL_IDLE;
                end
            end
            default: state_d = CPL_IDLE;
        endcase
        if (fifo_pop) num_done_d = num_done_q + 64'd1;
        rsp_pending_d = rsp_pending_q + PEND_W'(rsp_accept)
                      - (fifo_pop ? PEND_W'(fifo_first.lines) : PEND_W'(0));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= CPL_IDLE;
            rsp_pending_q <= '0;
            num_done_q    <= '0;
            ovf_q         <= 1'b0;
            st_valid_q    <= 1'b0;
            st_addr_q     <= '0;
            st_data_q     <= '0;
            intr_valid_q  <= 1'b0;
            intr_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            rsp_pending_q <= rsp_pending_d;
            num_done_q    <= num_done_d;
            ovf_q         <= ovf_d;
            st_valid_q    <= st_valid_d;
            st_addr_q     <= st_addr_d;
            st_data_q     <= st_data_d;
            intr_valid_q  <= intr_valid_d;
            intr_id_q     <= intr_id_d;
        end
    end

    assign status_wr_valid  = st_valid_q;
    assign status_wr_addr   = st_addr_q;
    assign status_wr_data   = st_data_q;
    assign num_cmds_done    = num_done_q;
    assign rsp_overflow_err = ovf_q;

`ifdef COPY_ENGINE_COMPLETION_INTR_EN
    assign head_use_mem = fifo_first.use_mem_status;
    assign intr_valid   = intr_valid_q;
    assign intr_id      = intr_id_q;
`else
    // Without the interrupt path every command completes through a status write
    assign head_use_mem = 1'b1;
    assign intr_valid   = 1'b0;
    assign intr_id      = '0;
    logic unused_intr;
    assign unused_intr = ^{intr_valid_q, intr_id_q, fifo_first.use_mem_status, fifo_first.intr_id};
`endif

endmodule

// File: tb/tb_copy_engine_completion.sv
// Directed bench for copy_engine_completion with hand-computed expectations.
`timescale 1ns/1ps
module tb_copy_engine_completion;
    import copy_engine_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    t_wr_cmd      cmd;
    logic         wr_rsp_valid;
    logic         status_wr_valid;
    logic         status_wr_ready;
    logic [63:0]  status_wr_addr;
    logic [63:0]  status_wr_data;
    logic         intr_valid;
    logic         intr_ready;
    t_cmd_intr_id intr_id;
    logic         intr_ack;
    logic [63:0]  num_cmds_done;
    logic         rsp_overflow_err;

    int n_checks = 0;
    int n_fail   = 0;
    int intr_cnt = 0;

    copy_engine_completion #(.MAX_OUTSTANDING_CMDS(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd              (cmd),
        .wr_rsp_valid     (wr_rsp_valid),
        .status_wr_valid  (status_wr_valid),
        .status_wr_ready  (status_wr_ready),
        .status_wr_addr   (status_wr_addr),
        .status_wr_data   (status_wr_data),
        .intr_valid       (intr_valid),
        .intr_ready       (intr_ready),
        .intr_id          (intr_id),
        .intr_ack         (intr_ack),
        .num_cmds_done    (num_cmds_done),
        .rsp_overflow_err (rsp_overflow_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (intr_valid === 1'b1) intr_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic push_cmd(input logic [7:0] lines, input logic use_mem,
                            input logic [7:0] iid, input logic [63:0] addr);
        cmd.num_lines       = lines;
        cmd.intr_id         = iid;
        cmd.use_mem_status  = use_mem;
        cmd.mem_status_addr = addr;
        cmd_valid = 1'b1;
        check("push_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    logic [63:0] cap_data [3];
    logic [63:0] cap_addr [3];
    int          n_wr;
    int          intr_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd = '0; wr_rsp_valid = 1'b0;
        status_wr_ready = 1'b0; intr_ready = 1'b0; intr_ack = 1'b1;

        // Reset values, with intr_ack held high during reset
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_st_valid", 64'(status_wr_valid), 64'd0);
        check("rst_intr_valid", 64'(intr_valid), 64'd0);
        check("rst_num_done", num_cmds_done, 64'd0);
        check("rst_ovf", 64'(rsp_overflow_err), 64'd0);
        step();
        intr_ack = 1'b0;
        reset_n  = 1'b1;
        step();
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_num_done", num_cmds_done, 64'd0);

        // Response with nothing tracked is dropped and flagged (sticky)
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        check("ovf_set", 64'(rsp_overflow_err), 64'd1);
        step(); step(); step();
        check("ovf_sticky", 64'(rsp_overflow_err), 64'd1);
        check("ovf_no_write", 64'(status_wr_valid), 64'd0);

        // Mem-status path: 4 lines at 0x1000
        do_reset();
        check("ovf_cleared", 64'(rsp_overflow_err), 64'd0);
        push_cmd(8'd4, 1'b1, 8'd0, 64'h1000);
        wr_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mem_valid_timing", 64'(status_wr_valid), (i == 3) ? 64'd1 : 64'd0);
        end
        wr_rsp_valid = 1'b0;
        check("mem_addr", status_wr_addr, 64'h1000);
        check("mem_data", status_wr_data, 64'd1);
        step();
        check("mem_hold_valid", 64'(status_wr_valid), 64'd1);
        check("mem_hold_addr", status_wr_addr, 64'h1000);
        check("mem_hold_data", status_wr_data, 64'd1);
        check("mem_no_pop", num_cmds_done, 64'd0);
        status_wr_ready = 1'b1;
        step();
        status_wr_ready = 1'b0;
        check("mem_done_valid", 64'(status_wr_valid), 64'd0);
        check("mem_done_cnt", num_cmds_done, 64'd1);

        // Pipelined 1, 256, 3 lines with 260 continuous responses
        do_reset();
        status_wr_ready = 1'b1;
        push_cmd(8'd1, 1'b1, 8'd0, 64'h2000);
        push_cmd(8'd0, 1'b1, 8'd0, 64'h3000);
        push_cmd(8'd3, 1'b1, 8'd0, 64'h4000);
        n_wr = 0;
        for (int c = 0; c < 280; c++) begin
            wr_rsp_valid = (c < 260);
            step();
            if (status_wr_valid) begin
                if (n_wr < 3) begin
                    cap_data[n_wr] = status_wr_data;
                    cap_addr[n_wr] = status_wr_addr;
                end
                n_wr++;
            end
        end
        wr_rsp_valid = 1'b0;
        check("pipe_count", 64'(n_wr), 64'd3);
        check("pipe_data0", cap_data[0], 64'd1);
        check("pipe_data1", cap_data[1], 64'd2);
        check("pipe_data2", cap_data[2], 64'd3);
        check("pipe_addr0", cap_addr[0], 64'h2000);
        check("pipe_addr1", cap_addr[1], 64'h3000);
        check("pipe_addr2", cap_addr[2], 64'h4000);
        check("pipe_num_done", num_cmds_done, 64'd3);
        check("pipe_no_ovf", 64'(rsp_overflow_err), 64'd0);
        // No leftover credit: a new 1-line command waits for its own response
        push_cmd(8'd1, 1'b1, 8'd0, 64'h5000);
        step(); step(); step();
        check("pipe_pending_zero", 64'(status_wr_valid), 64'd0);
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        check("pipe_extra_valid", 64'(status_wr_valid), 64'd1);
        check("pipe_extra_data", status_wr_data, 64'd4);
        step();
        check("pipe_extra_done", num_cmds_done, 64'd4);
        status_wr_ready = 1'b0;

        // Fill the FIFO without responses
        do_reset();
        for (int i = 0; i < 16; i++) push_cmd(8'd1, 1'b1, 8'd0, 64'(i) + 64'h100);
        check("full_cmd_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("full_still", 64'(cmd_ready), 64'd0);
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        check("full_head_valid", 64'(status_wr_valid), 64'd1);
        check("full_head_addr", status_wr_addr, 64'h100);
        status_wr_ready = 1'b1;
        step();
        status_wr_ready = 1'b0;
        check("full_pop_ready", 64'(cmd_ready), 64'd1);
        check("full_pop_done", num_cmds_done, 64'd1);

        // Reset while a status write is stalled
        do_reset();
        status_wr_ready = 1'b1;
        push_cmd(8'd1, 1'b1, 8'd0, 64'hA0);
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        step();
        check("midrst_first_done", num_cmds_done, 64'd1);
        status_wr_ready = 1'b0;
        push_cmd(8'd1, 1'b1, 8'd0, 64'hB0);
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        check("midrst_valid", 64'(status_wr_valid), 64'd1);
        check("midrst_data", status_wr_data, 64'd2);
        step();
        reset_n = 1'b0;
        step();
        check("midrst_valid_clr", 64'(status_wr_valid), 64'd0);
        check("midrst_done_clr", num_cmds_done, 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        reset_n = 1'b1;
        step();
        check("midrst_after_valid", 64'(status_wr_valid), 64'd0);
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        check("midrst_fifo_empty", 64'(rsp_overflow_err), 64'd1);

        do_reset();
`ifdef COPY_ENGINE_COMPLETION_INTR_EN
        // Interrupt path: 2 lines, intr_id 1, stalled ready then ack
        push_cmd(8'd2, 1'b0, 8'd1, 64'h0);
        wr_rsp_valid = 1'b1;
        step();
        check("intr_early", 64'(intr_valid), 64'd0);
        step();
        wr_rsp_valid = 1'b0;
        check("intr_valid", 64'(intr_valid), 64'd1);
        check("intr_id", 64'(intr_id), 64'd1);
        check("intr_no_status", 64'(status_wr_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            intr_ack = (k == 0);
            step();
            check("intr_stall_valid", 64'(intr_valid), 64'd1);
            check("intr_stall_id", 64'(intr_id), 64'd1);
        end
        intr_ack = 1'b0;
        check("intr_ack_ignored", num_cmds_done, 64'd0);
        intr_ready = 1'b1;
        step();
        intr_ready = 1'b0;
        check("intr_accepted", 64'(intr_valid), 64'd0);
        step(); step();
        check("intr_wait_ack", num_cmds_done, 64'd0);
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
        check("intr_done", num_cmds_done, 64'd1);
`else
        // Without the interrupt path, use_mem_status=0 still yields a status write
        intr_before = intr_cnt;
        intr_ack    = 1'b1;
        intr_ready  = 1'b1;
        push_cmd(8'd1, 1'b0, 8'd5, 64'hC0);
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        check("nointr_valid", 64'(status_wr_valid), 64'd1);
        check("nointr_data", status_wr_data, 64'd1);
        check("nointr_addr", status_wr_addr, 64'hC0);
        status_wr_ready = 1'b1;
        step();
        status_wr_ready = 1'b0;
        check("nointr_done", num_cmds_done, 64'd1);
        step();
        intr_ack   = 1'b0;
        intr_ready = 1'b0;
        check("nointr_never_valid", 64'(intr_cnt - intr_before), 64'd0);
        check("nointr_id", 64'(intr_id), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
